// File: rtl/multicycle_controller.sv
// Main control FSM with ALU and immediate decoders for a multicycle RV32I core.
// Optional memory wait-state handshake enabled by MULTICYCLE_CTRL_MEM_WAIT_EN (adds MemReady).
//
// state   | meaning
// --------+----------------------------------------------------
// FETCH   | read instruction at PC, latch IR/OldPC, PC <= PC+4
// DECODE  | read registers, precompute branch target OldPC+imm
// MEMADR  | compute load/store address rs1+imm
// MEMREAD | read data memory at ALUOut
// MEMWB   | write loaded data to rd
// MEMWR   | write rs2 data to memory at ALUOut
// EXECR   | R-type ALU operation rs1 op rs2
// ALUWB   | write ALUOut to rd
// EXECI   | I-type ALU operation rs1 op imm
// JAL     | PC <= target, ALUOut <= OldPC+4
// BEQ     | compare rs1/rs2, take branch on Zero
// TRAP    | unsupported opcode, hold until reset
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  input  logic       MemReady,
`endif
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       InstrDone,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMREAD = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECR   = 4'd6,
    ALUWB   = 4'd7,
    EXECI   = 4'd8,
    JAL     = 4'd9,
    BEQ     = 4'd10,
    TRAP    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t     state;
  state_t     next_state;
  state_t     dec_state;
  logic       illegal_q;
  logic       mem_ready;
  logic       pc_update;
  logic       branch;
  logic [1:0] alu_op;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= state_t'(RESET_STATE);
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == TRAP) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // While reset is high the selects mirror FETCH so the datapath sees a clean fetch setup.
  assign dec_state = reset ? state_t'(RESET_STATE) : state;

  always_comb begin
    next_state = FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    alu_op     = 2'b00;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    RegWrite   = 1'b0;
    InstrDone  = 1'b0;
    case (dec_state)
      FETCH: begin
        AdrSrc     = 1'b0;
        IRWrite    = mem_ready;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b10;
        alu_op     = 2'b00;
        ResultSrc  = 2'b10;
        pc_update  = mem_ready;
        next_state = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        alu_op  = 2'b00;
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECR;
          OP_ITYPE:     next_state = EXECI;
          OP_JAL:       next_state = JAL;
          OP_BEQ:       next_state = BEQ;
          default:      next_state = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        alu_op     = 2'b00;
        next_state = (op == OP_LW) ? MEMREAD : MEMWR;
      end
      MEMREAD: begin
        ResultSrc  = 2'b00;
        AdrSrc     = 1'b1;
        next_state = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        InstrDone  = 1'b1;
        next_state = FETCH;
      end
      MEMWR: begin
        ResultSrc  = 2'b00;
        AdrSrc     = 1'b1;
        MemWrite   = mem_ready;
        InstrDone  = mem_ready;
        next_state = mem_ready ? FETCH : MEMWR;
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        alu_op     = 2'b10;
        next_state = ALUWB;
      end
      ALUWB: begin
        ResultSrc  = 2'b00;
        RegWrite   = 1'b1;
        InstrDone  = 1'b1;
        next_state = FETCH;
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        alu_op     = 2'b10;
        next_state = ALUWB;
      end
      JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        alu_op     = 2'b00;
        ResultSrc  = 2'b00;
        pc_update  = 1'b1;
        next_state = ALUWB;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        alu_op     = 2'b01;
        ResultSrc  = 2'b00;
        branch     = 1'b1;
        InstrDone  = 1'b1;
        next_state = FETCH;
      end
      TRAP: begin
        next_state = TRAP;
      end
      default: begin
        next_state = FETCH;
      end
    endcase
    if (reset) begin
      pc_update = 1'b0;
      branch    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      InstrDone = 1'b0;
    end
  end

  assign PCWrite = pc_update | (branch & Zero);

  // Only R-type (op[5]=1) may subtract on funct3=000; addi shares funct3 but never subtracts.
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_LW, OP_ITYPE: ImmSrc = 2'b00;
      OP_SW:           ImmSrc = 2'b01;
      OP_BEQ:          ImmSrc = 2'b10;
      OP_JAL:          ImmSrc = 2'b11;
      default:         ImmSrc = 2'b00;
    endcase
  end

  assign Illegal = illegal_q;
  assign State   = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected output records and
// expected retirement states are queued by the stimulus and checked by a monitor.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  logic       MemReady;
`endif
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    .MemReady(MemReady),
`endif
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .InstrDone(InstrDone), .Illegal(Illegal),
    .State(State)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011;

  logic [21:0] exp_q[$];
  logic [3:0]  retire_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int trace_idx = 0;

  // {State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite, InstrDone, Illegal}
  function automatic logic [21:0] S(input logic [3:0] st, input logic pcw, adr, mw, irw,
                                    input logic [1:0] rs, sa, sb, input logic [2:0] alu,
                                    input logic [1:0] imm, input logic rw, dn, il);
    return {st, pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, dn, il};
  endfunction

  function automatic logic [21:0] f_fetch(input logic [1:0] imm);
    return S(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0, 0);
  endfunction
  function automatic logic [21:0] f_decode(input logic [1:0] imm);
    return S(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0, 0);
  endfunction
  // Reset cycle: strobes off, selects as in FETCH, state register not yet updated.
  function automatic logic [21:0] f_rst(input logic [3:0] st, input logic [1:0] imm, input logic il);
    return S(st, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0, il);
  endfunction

  always @(negedge clk) begin
    logic [21:0] e, a;
    a = {State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
         ALUControl, ImmSrc, RegWrite, InstrDone, Illegal};
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL trace[%0d] state=%0d got=%b expected=%b", trace_idx, State, a, e);
      end
      trace_idx++;
    end
    if (InstrDone === 1'b1) begin
      n_cmp++;
      if (retire_q.size() == 0) begin
        n_fail++;
        $display("FAIL retire_unexpected state=%0d got=InstrDone expected=none", State);
      end else begin
        logic [3:0] r;
        r = retire_q.pop_front();
        if (State !== r) begin
          n_fail++;
          $display("FAIL retire_state got=%0d expected=%0d", State, r);
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
  endtask

  task automatic do_r(input logic [2:0] f3, input logic f7, input logic z, input logic [2:0] alu);
    issue(OP_R, f3, f7, z);
    exp_q.push_back(f_fetch(2'b00));
    exp_q.push_back(f_decode(2'b00));
    exp_q.push_back(S(4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 2'b00, 0, 0, 0));
    exp_q.push_back(S(4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1, 0));
    retire_q.push_back(4'd7);
    run(4);
  endtask

  task automatic do_i_tail(input logic [2:0] alu);
    exp_q.push_back(f_decode(2'b00));
    exp_q.push_back(S(4'd8, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 2'b00, 0, 0, 0));
    exp_q.push_back(S(4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1, 0));
    retire_q.push_back(4'd7);
  endtask

  task automatic do_i(input logic [2:0] f3, input logic f7, input logic [2:0] alu);
    issue(OP_I, f3, f7, 1'b0);
    exp_q.push_back(f_fetch(2'b00));
    do_i_tail(alu);
    run(4);
  endtask

  task automatic do_lw();
    issue(OP_LW, 3'b010, 1'b0, 1'b0);
    exp_q.push_back(f_fetch(2'b00));
    exp_q.push_back(f_decode(2'b00));
    exp_q.push_back(S(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0));
    exp_q.push_back(S(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0));
    exp_q.push_back(S(4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1, 0));
    retire_q.push_back(4'd4);
    run(5);
  endtask

  task automatic do_sw_head();
    issue(OP_SW, 3'b010, 1'b0, 1'b1);
    exp_q.push_back(f_fetch(2'b01));
    exp_q.push_back(f_decode(2'b01));
    exp_q.push_back(S(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0, 0));
  endtask

  task automatic do_sw();
    do_sw_head();
    exp_q.push_back(S(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 1, 0));
    retire_q.push_back(4'd5);
    run(4);
  endtask

  task automatic do_beq(input logic z);
    issue(OP_BEQ, 3'b000, 1'b0, z);
    exp_q.push_back(f_fetch(2'b10));
    exp_q.push_back(f_decode(2'b10));
    exp_q.push_back(S(4'd10, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 1, 0));
    retire_q.push_back(4'd10);
    run(3);
  endtask

  task automatic do_jal();
    issue(OP_JAL, 3'b000, 1'b1, 1'b1);
    exp_q.push_back(f_fetch(2'b11));
    exp_q.push_back(f_decode(2'b11));
    exp_q.push_back(S(4'd9, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0, 0));
    exp_q.push_back(S(4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 1, 1, 0));
    retire_q.push_back(4'd7);
    run(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    MemReady = 1'b1;
`endif
    issue(OP_R, 3'b000, 1'b0, 1'b0);
    run(1);
    exp_q.push_back(f_rst(4'd0, 2'b00, 1'b0));
    run(1);
    reset = 1'b0;

    do_r(3'b000, 1'b0, 1'b0, 3'b000);   // add
    do_lw();
    do_sw();
    do_beq(1'b1);
    do_beq(1'b0);
    do_r(3'b000, 1'b1, 1'b0, 3'b001);   // sub
    do_i(3'b000, 1'b1, 3'b000);         // addi with funct7b5 set
    do_r(3'b111, 1'b0, 1'b1, 3'b010);   // and, Zero high must not leak into PCWrite
    do_r(3'b110, 1'b0, 1'b0, 3'b011);   // or
    do_r(3'b010, 1'b0, 1'b0, 3'b101);   // slt
    do_i(3'b110, 1'b0, 3'b011);         // ori
    do_i(3'b111, 1'b0, 3'b010);         // andi
    do_i(3'b010, 1'b0, 3'b101);         // slti
    do_i(3'b001, 1'b0, 3'b000);         // unsupported funct3 falls back to add
    do_jal();

    // Reset in MEMREAD abandons the load: no MEMWB, no RegWrite, no retirement.
    issue(OP_LW, 3'b010, 1'b0, 1'b0);
    exp_q.push_back(f_fetch(2'b00));
    exp_q.push_back(f_decode(2'b00));
    exp_q.push_back(S(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0));
    run(3);
    reset = 1'b1;
    exp_q.push_back(f_rst(4'd3, 2'b00, 1'b0));
    run(1);
    reset = 1'b0;
    do_r(3'b000, 1'b0, 1'b0, 3'b000);

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    MemReady = 1'b0;
    issue(OP_I, 3'b000, 1'b0, 1'b0);
    repeat (3) exp_q.push_back(S(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0, 0));
    run(3);
    MemReady = 1'b1;
    exp_q.push_back(f_fetch(2'b00));
    do_i_tail(3'b000);
    run(4);
    do_sw_head();
    run(3);
    MemReady = 1'b0;
    exp_q.push_back(S(4'd5, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0, 0));
    run(1);
    MemReady = 1'b1;
    exp_q.push_back(S(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 1, 0));
    retire_q.push_back(4'd5);
    run(1);
`endif

    // Illegal opcode traps and holds; reset clears the sticky flag.
    issue(7'b1111111, 3'b000, 1'b0, 1'b1);
    exp_q.push_back(f_fetch(2'b00));
    exp_q.push_back(f_decode(2'b00));
    repeat (20) exp_q.push_back(S(4'd11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 1));
    run(22);
    reset = 1'b1;
    exp_q.push_back(f_rst(4'd11, 2'b00, 1'b1));
    run(1);
    reset = 1'b0;
    do_r(3'b000, 1'b1, 1'b0, 3'b001);

    n_cmp++;
    if (exp_q.size() != 0 || retire_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d/%0d pending expected=0/0", exp_q.size(), retire_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
